// File: rtl/attopu_sequencer.sv
// Multi-cycle control sequencer for the attopu core: fetch/decode/exec/mem/write-back
// with memory handshakes, halt/resume, a memory-wait watchdog and a retired counter.
module attopu_sequencer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       opcode,
  input  logic             dec_reg_we,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             halt_req,
  input  logic             resume,
  output logic             imem_req,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_we,
  output logic             pc_en,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;

  localparam logic [7:0] WD_LAST = 8'(MEM_TIMEOUT - 1);

  logic [2:0] stateNext;
  logic [7:0] wdCnt;
  logic [7:0] wdNext;
  logic       clsMemRd;
  logic       clsMemWr;
  logic       clsWriter;
  logic       memWait;
  logic       timeout;

  function automatic logic isWriterOp(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b001) || (op == 3'b011);
  endfunction

  // Strobes are held low while reset is asserted, even though state already reads FETCH.
  always_comb begin
    imem_req = rst_n && (state == FETCH);
    ir_load  = imem_req && imem_ack;
    dmem_req = rst_n && (state == MEM);
    dmem_we  = dmem_req && clsMemWr;
    reg_we   = rst_n && (state == WB) && dec_reg_we && clsWriter;
    pc_en    = rst_n && (state == WB);
    halted   = rst_n && (state == HALT);
  end

  always_comb begin
    memWait   = ((state == FETCH) && !imem_ack) || ((state == MEM) && !dmem_ack);
    timeout   = memWait && (wdCnt == WD_LAST);
    stateNext = state;
    wdNext    = 8'd0;
    case (state)
      FETCH:   if (imem_ack) stateNext = DECODE;
      DECODE:  stateNext = EXEC;
      EXEC:    stateNext = (clsMemRd || clsMemWr) ? MEM : WB;
      MEM:     if (dmem_ack) stateNext = WB;
      WB:      stateNext = halt_req ? HALT : FETCH;
      HALT:    if (resume) stateNext = FETCH;
      default: stateNext = FETCH;
    endcase
    if (memWait) wdNext = wdCnt + 8'd1;
    // An ack on the last permitted cycle clears memWait, so it beats the timeout.
    if (timeout) begin
      stateNext = HALT;
      wdNext    = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      wdCnt     <= 8'd0;
      clsMemRd  <= 1'b0;
      clsMemWr  <= 1'b0;
      clsWriter <= 1'b0;
      fault     <= 1'b0;
      retired   <= '0;
    end else begin
      state <= stateNext;
      wdCnt <= wdNext;
      if (state == DECODE) begin
        clsMemRd  <= (opcode == 3'b011);
        clsMemWr  <= (opcode == 3'b101);
        clsWriter <= isWriterOp(opcode);
      end
      if (timeout) fault <= 1'b1;
      else if ((state == HALT) && resume) fault <= 1'b0;
      if (state == WB) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_attopu_sequencer.sv
// Randomized instruction-level bench for attopu_sequencer: each instruction is expanded
// into its expected cycle trace from the phase rules and compared cycle by cycle.
module tb_attopu_sequencer;

  localparam int TO   = 4;
  localparam int CNTW = 4;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2:0]      opcode;
  logic            dec_reg_we, imem_ack, dmem_ack, halt_req, resume;
  logic            imem_req, ir_load, dmem_req, dmem_we, reg_we, pc_en, halted, fault;
  logic [2:0]      state;
  logic [CNTW-1:0] retired;

  int nChecks = 0;
  int nErrors = 0;
  int expRetired = 0;
  logic expFault = 1'b0;

  attopu_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .dec_reg_we(dec_reg_we),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .halt_req(halt_req), .resume(resume),
    .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .reg_we(reg_we), .pc_en(pc_en), .halted(halted), .fault(fault),
    .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] rop();
    return 3'($urandom_range(0, 7));
  endfunction

  // One clock cycle: drive inputs after the falling edge, then check outputs.
  task automatic cyc(input logic [2:0] op, input logic iAck, input logic dAck,
                     input logic hReq, input logic res, input logic dWe,
                     input logic [2:0] eSt, input logic eIreq, input logic eIrl,
                     input logic eDreq, input logic eDwe, input logic eRwe, input logic ePc);
    @(negedge clk);
    opcode = op; imem_ack = iAck; dmem_ack = dAck;
    halt_req = hReq; resume = res; dec_reg_we = dWe;
    #1;
    chk("state",    32'(state),    32'(eSt));
    chk("imem_req", 32'(imem_req), 32'(eIreq));
    chk("ir_load",  32'(ir_load),  32'(eIrl));
    chk("dmem_req", 32'(dmem_req), 32'(eDreq));
    chk("dmem_we",  32'(dmem_we),  32'(eDwe));
    chk("reg_we",   32'(reg_we),   32'(eRwe));
    chk("pc_en",    32'(pc_en),    32'(ePc));
    chk("halted",   32'(halted),   32'(eSt == S_HALT));
    chk("fault",    32'(fault),    32'(expFault));
    chk("retired",  32'(retired),  32'(expRetired % (1 << CNTW)));
  endtask

  task automatic checkReset(input string tag);
    chk({tag, "_state"},    32'(state),    32'(S_FETCH));
    chk({tag, "_imem_req"}, 32'(imem_req), 32'(0));
    chk({tag, "_ir_load"},  32'(ir_load),  32'(0));
    chk({tag, "_dmem_req"}, 32'(dmem_req), 32'(0));
    chk({tag, "_dmem_we"},  32'(dmem_we),  32'(0));
    chk({tag, "_reg_we"},   32'(reg_we),   32'(0));
    chk({tag, "_pc_en"},    32'(pc_en),    32'(0));
    chk({tag, "_halted"},   32'(halted),   32'(0));
    chk({tag, "_fault"},    32'(fault),    32'(0));
    chk({tag, "_retired"},  32'(retired),  32'(0));
  endtask

  // iWait/dWait: cycles before the ack; a wait of TO or more never acks and times out.
  task automatic runInstr(input logic [2:0] op, input logic rwe, input int iWait,
                          input int dWait, input logic hAtWb);
    logic isMem, isSt, writes, aborted, ack, done;
    int c, nHold;
    isMem   = (op == 3'b011) || (op == 3'b101);
    isSt    = (op == 3'b101);
    writes  = (op == 3'b000) || (op == 3'b001) || (op == 3'b011);
    aborted = 1'b0;

    c = 0; done = 1'b0;
    while (!done) begin
      ack = (c == iWait);
      cyc(rop(), ack, rb(), rb(), rb(), rb(), S_FETCH, 1'b1, ack, 1'b0, 1'b0, 1'b0, 1'b0);
      c++;
      done = ack || (c == TO);
    end
    aborted = (iWait >= TO);

    if (!aborted) begin
      cyc(op,    rb(), rb(), rb(), rb(), rb(), S_DECODE, 0, 0, 0, 0, 0, 0);
      cyc(rop(), rb(), rb(), rb(), rb(), rb(), S_EXEC,   0, 0, 0, 0, 0, 0);
      if (isMem) begin
        c = 0; done = 1'b0;
        while (!done) begin
          ack = (c == dWait);
          cyc(rop(), rb(), ack, rb(), rb(), rb(), S_MEM, 1'b0, 1'b0, 1'b1, isSt, 1'b0, 1'b0);
          c++;
          done = ack || (c == TO);
        end
        aborted = (dWait >= TO);
      end
    end

    if (!aborted) begin
      cyc(rop(), rb(), rb(), hAtWb, 1'b1, rwe, S_WB, 0, 0, 0, 0, rwe && writes, 1'b1);
      expRetired++;
    end else begin
      expFault = 1'b1;
    end

    if (aborted || hAtWb) begin
      nHold = $urandom_range(0, 2);
      for (int h = 0; h < nHold; h++)
        cyc(rop(), rb(), rb(), rb(), 1'b0, rb(), S_HALT, 0, 0, 0, 0, 0, 0);
      cyc(rop(), rb(), rb(), rb(), 1'b1, rb(), S_HALT, 0, 0, 0, 0, 0, 0);
      expFault = 1'b0;
    end
  endtask

  task automatic resetInMem();
    cyc(3'b011, 1, 0, 0, 0, 0, S_FETCH,  1, 1, 0, 0, 0, 0);
    cyc(3'b011, 0, 0, 0, 0, 0, S_DECODE, 0, 0, 0, 0, 0, 0);
    cyc(3'b000, 0, 0, 0, 0, 0, S_EXEC,   0, 0, 0, 0, 0, 0);
    cyc(3'b000, 0, 0, 0, 0, 0, S_MEM,    0, 0, 1, 0, 0, 0);
    #1 rst_n = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0; halt_req = 1'b0; resume = 1'b0;
    #1;
    expRetired = 0;
    expFault   = 1'b0;
    checkReset("rst_mid_mem");
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = 3'b000; dec_reg_we = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
    halt_req = 1'b0; resume = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkReset("reset");
    rst_n = 1'b1;

    runInstr(3'b000, 1'b1, 0, 0, 1'b0);
    runInstr(3'b101, 1'b1, 0, 3, 1'b0);
    runInstr(3'b011, 1'b1, 0, 0, 1'b0);
    runInstr(3'b110, 1'b1, 0, 0, 1'b0);
    runInstr(3'b010, 1'b1, 1, 0, 1'b0);
    runInstr(3'b100, 1'b1, 0, 0, 1'b0);
    runInstr(3'b000, 1'b1, TO, 0, 1'b0);
    runInstr(3'b001, 1'b1, TO - 1, 0, 1'b0);
    runInstr(3'b011, 1'b1, 0, TO, 1'b0);
    runInstr(3'b101, 1'b0, 0, TO - 1, 1'b0);
    runInstr(3'b000, 1'b1, 0, 0, 1'b1);
    runInstr(3'b111, 1'b0, 2, 0, 1'b0);
    resetInMem();
    runInstr(3'b001, 1'b1, 0, 0, 1'b0);

    for (int i = 0; i < 200; i++)
      runInstr(rop(), rb(), $urandom_range(0, TO + 1), $urandom_range(0, TO + 1),
               ($urandom_range(0, 4) == 0));

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/attopu_sequencer.md
Name: attopu_sequencer

Overview:
Multi-cycle control FSM for the attopu core. It sequences each instruction through fetch, decode, execute, optional data-memory access and write-back. It drives request/acknowledge handshakes to instruction and data memory, and gates the decoder's write enables so that state only changes in the correct phase. It also provides halt/resume, a memory-wait watchdog and a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 255, max consecutive cycles a memory request may stay unacknowledged before a fault (≥1, fits 8 bits)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  3  instruction[15:13] from the instruction register
dec_reg_we  in  1  regFileWE from decoder (combinational)
imem_ack  in  1  instruction memory done; sampled while imem_req=1
dmem_ack  in  1  data memory done; sampled while dmem_req=1
halt_req  in  1  level; halts after current instruction retires
resume  in  1  pulse; leaves HALT
imem_req  out  1  instruction fetch request
ir_load  out  1  one-cycle strobe: latch fetched word into IR
dmem_req  out  1  data memory request
dmem_we  out  1  data write qualifier, valid with dmem_req
reg_we  out  1  gated register-file write enable
pc_en  out  1  one-cycle strobe: PC takes nextPC (increment/branch)
halted  out  1  1 while in HALT
fault  out  1  sticky watchdog error
state  out  3  current FSM state encoding
retired  out  CNT_W  count of retired instructions, wraps

Behaviour:
- Reset (async, rst_n=0): state=FETCH; all strobes (imem_req, ir_load, dmem_req, dmem_we, reg_we, pc_en) = 0; halted=0; fault=0; retired=0; watchdog=0.
- Encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Values 6–7 are unreachable; if entered, go to FETCH.
- Outputs are combinational from state, plus registered class/ack where noted.
- FETCH:
  - imem_req=1.
  - On a cycle with imem_ack=1: ir_load=1 in that same cycle, next state DECODE, watchdog cleared.
  - Otherwise the watchdog increments.
- DECODE: one cycle. Register the opcode class: MEMRD=011, MEMWR=101, WRITER=000/001/011. Next state EXEC.
- EXEC: one cycle.
  - Next state MEM if the class is MEMRD or MEMWR; otherwise WB.
  - Opcodes 010 and 100 are NOPs: go to WB with no writes.
- MEM:
  - dmem_req=1; dmem_we=1 only for MEMWR.
  - On dmem_ack=1: next state WB, watchdog cleared. Otherwise the watchdog increments.
  - For MEMRD, load data is assumed valid in the WB cycle.
- WB: one cycle.
  - reg_we = dec_reg_we AND class WRITER, so a store or branch never writes a register.
  - pc_en=1; retired += 1 (mod 2^CNT_W).
  - Next state HALT if halt_req=1, else FETCH.
- HALT: halted=1; all strobes 0. On resume=1: next state FETCH and fault cleared. halt_req is ignored while in HALT.
- Watchdog:
  - If imem_req or dmem_req has been 1 for MEM_TIMEOUT consecutive cycles without ack, then at the end of the MEM_TIMEOUT-th cycle: state→HALT, fault=1.
  - No ir_load, pc_en or reg_we is issued for the aborted instruction, and retired does not increment.
  - An ack in the MEM_TIMEOUT-th cycle wins over the timeout.
- Latency with zero-wait memory (ack in the same cycle as req):
  - non-memory instruction = 4 cycles (FETCH, DECODE, EXEC, WB);
  - LD/ST register = 5 cycles.
  - Each wait cycle adds one.
- Branches: the decoder's nextPCSel is honoured by the PC only during the pc_en cycle. A branch not taken (zFlag=0) simply increments the PC.
- An ack while req=0 is ignored.
- halt_req asserted mid-instruction does not abort; it takes effect after WB.
- resume outside HALT is ignored.
- Reset asserted mid-operation drops all strobes immediately; any in-flight memory transaction is abandoned.
- Invariants: at most one of imem_req/dmem_req is high; ir_load, pc_en and reg_we are each at most one cycle wide per instruction.

Test Plan:
- ALU op 000, acks in the same cycle: state sequence 0,1,2,4,0. ir_load at cycle 0; reg_we=1 and pc_en=1 at cycle 3; retired=1.
- ST (opcode 101) with dmem_ack delayed 3 cycles: dmem_req and dmem_we high for 4 cycles; reg_we stays 0; pc_en once; 8 cycles total.
- LD (opcode 011) with dec_reg_we=1: dmem_we=0 throughout MEM; reg_we=1 only in WB. BRZ (opcode 110) with dec_reg_we forced 1: reg_we stays 0.
- MEM_TIMEOUT=4, imem_ack held 0: after 4 FETCH cycles, halted=1, fault=1, retired unchanged. Then pulse resume: fault=0, FETCH resumes. Repeat with ack arriving in cycle 4: no fault.
- halt_req raised during EXEC: instruction completes (pc_en pulse), then HALT. A resume pulse in the same cycle as WB is ignored; a later resume restarts fetch.
- rst_n pulsed low during MEM with dmem_req=1: dmem_req drops asynchronously, all outputs at reset values; after release, FETCH begins.
